// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and decode handoff.
// Both handshakes transfer on a cycle where valid (imem_req / instr_valid) and ready (imem_gnt / instr_ready) are both high.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory requests, prefetch FIFO and redirect handling with stale-response discard.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic               fetch_misalign,
`endif
    output logic [0:0]         dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [0:0] { ST_RUN = 1'b0, ST_HALT = 1'b1 } state_t;
`else
    typedef enum logic [0:0] { ST_RUN = 1'b0 } state_t;
`endif

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_pcq_wr;
    logic [AW-1:0]   r_pcq_rd;
    logic [XLEN-1:0] r_fifo_instr [DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [XLEN-1:0] r_pcq        [DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_misalign;
`endif

    logic            w_pop;
    logic            w_req;
    logic            w_grant;
    logic            w_rsp;
    logic            w_keep;
    logic [CW:0]     w_used;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_target;

    assign w_pop = (r_count != '0) && bus.instr_ready;

    // A head entry leaving this cycle frees its slot for a new request, which keeps 1 instr/cycle with DEPTH=2.
    assign w_used  = {1'b0, r_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);
    assign w_req   = !rst && (r_state == ST_RUN) && !bus.redirect && (w_used < (CW+1)'(DEPTH));
    assign w_grant = w_req && bus.imem_gnt;
    assign w_rsp   = bus.imem_rvalid && (r_outstanding != '0);
    assign w_keep  = w_rsp && (r_discard == '0) && !bus.redirect;

    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_rsp);
    assign w_target   = {bus.redirect_pc[XLEN-1:2], 2'b00};

`ifndef FETCH_MISALIGN_TRAP_EN
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];
`endif

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = r_fifo_instr[r_rd_ptr];
    assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];
    assign dbg_state       = r_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign  = r_misalign;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
                r_pcq[i]        <= '0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            r_outstanding <= w_out_next;
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_discard  <= w_out_next;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pcq_wr   <= '0;
                r_pcq_rd   <= '0;
                r_fetch_pc <= w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    r_state    <= ST_HALT;
                    r_misalign <= 1'b1;
                end else begin
                    r_state    <= ST_RUN;
                    r_misalign <= 1'b0;
                end
`endif
            end else begin
                if (w_grant) begin
                    r_pcq[r_pcq_wr] <= r_fetch_pc;
                    r_pcq_wr        <= r_pcq_wr + AW'(1);
                    r_fetch_pc      <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_keep) begin
                    r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                    r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
                    r_wr_ptr               <= r_wr_ptr + AW'(1);
                    r_pcq_rd               <= r_pcq_rd + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rvalid && (r_outstanding == '0)));
            assert (!(w_keep && !w_pop && (r_count == CW'(DEPTH))));
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model returning addr ^ 32'hA5A5_0000.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the misaligned-redirect halt.
module tb_instr_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:0] dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .dbg_state      (dbg_state)
    );

    // Memory model: a grant seen at a rising edge returns mem_lat edges later.
    logic        pipe_v [1:3];
    logic [31:0] pipe_a [1:3];

    always @(posedge clk) begin
        logic        g;
        logic [31:0] a;
        g = bus.imem_req && bus.imem_gnt;
        a = bus.imem_addr;
        #1;
        if (rst) begin
            for (int i = 1; i <= 3; i++) begin
                pipe_v[i] = 1'b0;
                pipe_a[i] = '0;
            end
        end else begin
            for (int i = 1; i < 3; i++) begin
                pipe_v[i] = pipe_v[i+1];
                pipe_a[i] = pipe_a[i+1];
            end
            pipe_v[3] = 1'b0;
            if (g) begin
                pipe_v[mem_lat] = 1'b1;
                pipe_a[mem_lat] = a;
            end
        end
        bus.imem_rvalid = pipe_v[1];
        bus.imem_rdata  = pipe_a[1] ^ 32'hA5A5_0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset(input int lat, input logic ready);
        @(negedge clk);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.instr_ready = ready;
        mem_lat         = lat;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",       32'(bus.imem_req),    32'd0);
        chk("rst_valid",     32'(bus.instr_valid), 32'd0);
        chk("rst_instr",     bus.instr,            32'd0);
        chk("rst_instr_pc",  bus.instr_pc,         32'd0);
        chk("rst_state",     32'(dbg_state),       32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign",  32'(fetch_misalign),  32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;

        // 1: back-to-back fetch from reset with a 1-cycle memory
        do_reset(1, 1'b1);
        #1;
        chk("t1_req0",    32'(bus.imem_req),    32'd1);
        chk("t1_addr0",   bus.imem_addr,        32'h0000_0000);
        cyc();
        chk("t1_latency", 32'(bus.instr_valid), 32'd0);
        chk("t1_addr1",   bus.imem_addr,        32'h0000_0004);
        cyc();
        chk("t1_valid0",  32'(bus.instr_valid), 32'd1);
        chk("t1_pc0",     bus.instr_pc,         32'h0000_0000);
        chk("t1_instr0",  bus.instr,            32'hA5A5_0000);
        cyc();
        chk("t1_pc4",     bus.instr_pc,         32'h0000_0004);
        chk("t1_instr4",  bus.instr,            32'hA5A5_0004);
        cyc();
        chk("t1_pc8",     bus.instr_pc,         32'h0000_0008);
        chk("t1_instr8",  bus.instr,            32'hA5A5_0008);
        cyc();
        chk("t1_valid12", 32'(bus.instr_valid), 32'd1);
        chk("t1_pc12",    bus.instr_pc,         32'h0000_000C);

        // 2: decode stalled, FIFO fills to DEPTH and requests stop
        do_reset(1, 1'b0);
        cyc();
        chk("t2_req1",    32'(bus.imem_req),    32'd1);
        chk("t2_addr1",   bus.imem_addr,        32'h0000_0004);
        cyc();
        chk("t2_req_full", 32'(bus.imem_req),   32'd0);
        repeat (9) cyc();
        chk("t2_req_held", 32'(bus.imem_req),   32'd0);
        chk("t2_hold_pc",  bus.instr_pc,        32'h0000_0000);
        bus.instr_ready = 1'b1;
        #1;
        chk("t2_resume_req",  32'(bus.imem_req), 32'd1);
        chk("t2_resume_addr", bus.imem_addr,     32'h0000_0008);
        cyc();
        chk("t2_pc4",     bus.instr_pc,         32'h0000_0004);
        chk("t2_instr4",  bus.instr,            32'hA5A5_0004);
        cyc();
        chk("t2_valid8",  32'(bus.instr_valid), 32'd1);
        chk("t2_pc8",     bus.instr_pc,         32'h0000_0008);

        // 3: 3-cycle memory, redirect with two requests in flight
        do_reset(3, 1'b1);
        cyc();
        cyc();
        chk("t3_req_full", 32'(bus.imem_req),   32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        cyc();
        bus.redirect = 1'b0;
        chk("t3_flush",   32'(bus.instr_valid), 32'd0);
        chk("t3_addr",    bus.imem_addr,        32'h0000_0100);
        wait_valid("t3_wait", 20);
        chk("t3_pc100",   bus.instr_pc,         32'h0000_0100);
        chk("t3_ins100",  bus.instr,            32'hA5A5_0100);
        cyc();
        chk("t3_valid104", 32'(bus.instr_valid), 32'd1);
        chk("t3_pc104",   bus.instr_pc,         32'h0000_0104);

        // 4: redirect coincides with a response and a pop
        do_reset(1, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("t4_pop_valid", 32'(bus.instr_valid), 32'd1);
        chk("t4_pop_pc",  bus.instr_pc,         32'h0000_0004);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        #1;
        chk("t4_req_redir", 32'(bus.imem_req),  32'd0);
        cyc();
        bus.redirect = 1'b0;
        chk("t4_flush",   32'(bus.instr_valid), 32'd0);
        #1;
        chk("t4_req",     32'(bus.imem_req),    32'd1);
        chk("t4_addr",    bus.imem_addr,        32'h0000_0200);
        cyc();
        chk("t4_gap",     32'(bus.instr_valid), 32'd0);
        cyc();
        chk("t4_valid",   32'(bus.instr_valid), 32'd1);
        chk("t4_pc200",   bus.instr_pc,         32'h0000_0200);
        chk("t4_ins200",  bus.instr,            32'hA5A5_0200);

        // 5: PC wraps past the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        cyc();
        bus.redirect = 1'b0;
        #1;
        chk("t5_addr_top", bus.imem_addr,       32'hFFFF_FFFC);
        cyc();
        chk("t5_wrap",    bus.imem_addr,        32'h0000_0000);
        cyc();
        chk("t5_pc_top",  bus.instr_pc,         32'hFFFF_FFFC);
        chk("t5_ins_top", bus.instr,            32'h5A5A_FFFC);
        cyc();
        chk("t5_pc0",     bus.instr_pc,         32'h0000_0000);
        chk("t5_ins0",    bus.instr,            32'hA5A5_0000);

        // 6: misaligned redirect target
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        cyc();
        bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_misalign",  32'(fetch_misalign),  32'd1);
        chk("t6_halt",      32'(dbg_state),       32'd1);
        chk("t6_req_off",   32'(bus.imem_req),    32'd0);
        chk("t6_flush",     32'(bus.instr_valid), 32'd0);
        repeat (3) cyc();
        chk("t6_mis_held",  32'(fetch_misalign),  32'd1);
        chk("t6_req_held",  32'(bus.imem_req),    32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        cyc();
        bus.redirect = 1'b0;
        chk("t6_mis_clr",   32'(fetch_misalign),  32'd0);
        chk("t6_run",       32'(dbg_state),       32'd0);
        #1;
        chk("t6_req_on",    32'(bus.imem_req),    32'd1);
        chk("t6_addr",      bus.imem_addr,        32'h0000_0200);
        wait_valid("t6_wait", 10);
        chk("t6_pc200",     bus.instr_pc,         32'h0000_0200);
`else
        #1;
        chk("t6_req",       32'(bus.imem_req),    32'd1);
        chk("t6_addr",      bus.imem_addr,        32'h0000_0100);
        wait_valid("t6_wait", 10);
        chk("t6_pc100",     bus.instr_pc,         32'h0000_0100);
        chk("t6_ins100",    bus.instr,            32'hA5A5_0100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the decode/control stage. Holds the PC and issues word requests to instruction memory. Buffers returned words in a small prefetch FIFO and presents one instruction per cycle (with its PC) to decode over a valid/ready handshake. Handles branch redirects, including discarding responses that are in flight when the redirect arrives.

Parameters:
XLEN, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, prefetch FIFO entries and maximum outstanding memory requests (power of 2, ≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  request valid to instruction memory
imem_addr  out  XLEN  word-aligned request address
imem_gnt  in  1  memory accepts request this cycle (transfer when imem_req && imem_gnt)
imem_rvalid  in  1  response data valid; responses in order, ≥1 cycle after grant
imem_rdata  in  XLEN  response instruction word
redirect  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  XLEN  new fetch target
instr_valid  out  1  instr/instr_pc valid toward decode
instr_ready  in  1  decode accepts (transfer when instr_valid && instr_ready)
instr  out  XLEN  instruction word to control unit/decode
instr_pc  out  XLEN  PC of instr
fetch_misalign  out  1  present only with FETCH_MISALIGN_TRAP_EN (see below)

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=RUN. Outputs imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_misalign=0.
- imem_req=1 when state=RUN, !redirect, and (FIFO count + outstanding) < DEPTH. imem_addr=fetch_pc. imem_req/imem_addr stay stable until granted, unless a redirect occurs.
- On grant: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1. PC of the request is pushed to an internal PC queue.
- On imem_rvalid: outstanding -= 1. If discard>0, drop the word and decrement discard. Else push {rdata, queued PC} into the FIFO. Space is guaranteed by the issue rule; overflow is an assertion failure.
- instr_valid = FIFO not empty; instr/instr_pc = FIFO head (combinational from storage). Pop on instr_valid && instr_ready.
- Latency: first instr_valid no earlier than 2 cycles after rst deasserts with a 1-cycle memory. Zero-stall throughput is 1 instr/cycle when DEPTH≥2 and memory latency is 1.
- Redirect (highest priority): FIFO flushed (instr_valid=0 next cycle); PC queue cleared; fetch_pc=redirect_pc with low 2 bits cleared; discard = outstanding count after this cycle's grant and response updates. A grant coinciding with a redirect cannot occur because imem_req is low during redirect. A response arriving in the same cycle as a redirect is dropped and does not add to discard. A pop in the same cycle as a redirect is permitted; the popped instruction is the one presented that cycle.
- Simultaneous push and pop on a full FIFO: pop first, count unchanged.
- Reset mid-operation: in-flight responses are not tracked across reset. The memory side must also be reset by the same rst.
- Counters (outstanding, discard, count) are log2(DEPTH)+1 bits wide and never underflow. An rvalid with outstanding=0 is an assertion failure.

Optional Feature:
FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect_pc with bits[1:0]≠0 sets state=HALT. The FIFO is flushed, imem_req is held at 0, and fetch_misalign is held at 1 until the next redirect with an aligned target, which resumes RUN.
- Undefined: the fetch_misalign port and HALT state are absent; bits[1:0] are silently forced to 0.

Test Plan:
1. Reset release, 1-cycle memory returning addr^32'hA5A5_0000, instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive cycles with matching instr; first instr_valid 2 cycles after reset.
2. instr_ready=0 for 10 cycles -> FIFO holds exactly DEPTH entries (PCs 0,4); imem_req drops; resuming ready delivers 0,4,8 in order with no loss or duplicates.
3. Memory latency 3, redirect to 32'h100 while 2 requests are outstanding -> both stale responses discarded; next delivered instr_pc=32'h100, then 32'h104.
4. Redirect in the same cycle as imem_rvalid and an instr pop -> popped word delivered, arriving word dropped, discard equals remaining outstanding; next instr_pc=redirect_pc.
5. fetch_pc=32'hFFFF_FFFC -> following request address 32'h0000_0000 (wrap).
6. With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102 -> fetch_misalign=1, imem_req=0 held; redirect to 32'h200 -> fetch_misalign=0, fetch resumes at 32'h200. Without the macro, the same stimulus fetches 32'h100.
